lcd_spi_rx: RTL and testbench
=============================

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 Parameter C_color_bits, default 16, pixel width; only 16 (RGB565, two bytes per pixel) SHALL be supported.
REQ-002 Parameter C_x_max, default 127, last column index; C_y_max, default 159, last row index.
REQ-003 clk  input  1  system clock, all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 oled_cs, oled_clk, oled_mosi, oled_dc  input  1 each  SPI lines from the LCD driver (asynchronous to clk).
REQ-006 pix_valid  output  1  one-cycle strobe, pixel written.
REQ-007 pix_x  output  7, pix_y  output  8, pix_color  output  C_color_bits  pixel address and data, valid with pix_valid.
REQ-008 cmd_valid  output  1, cmd_code  output  8  one-cycle strobe plus opcode for every received command byte.

Function
REQ-009 The four SPI inputs SHALL pass through 2-flop synchronizers; clk SHALL be at least 4x oled_clk.
REQ-010 Mode 0: mosi SHALL be sampled on each synchronized oled_clk rising edge while oled_cs is low, MSB first.
REQ-011 oled_cs high SHALL clear the bit counter and discard any partial byte; decoder state SHALL be retained.
REQ-012 A byte SHALL complete on the 8th sampled edge; oled_dc sampled at that edge SHALL classify it (0 = command, 1 = data).
REQ-013 Command byte: cmd_valid/cmd_code SHALL pulse one cycle after byte completion, and the FSM SHALL enter the state for the opcode, aborting any in-progress sequence and discarding any pending pixel high byte.
REQ-014 States: IDLE, CASET (0x2A), RASET (0x2B), RAMWR (0x2C), SKIP (any other opcode); data bytes in IDLE/SKIP SHALL be ignored.
REQ-015 CASET/RASET: param index 0..3 = start_hi, start_lo, end_hi, end_lo; on the 4th byte the window SHALL update using the low 7 (x) or 8 (y) bits; further data bytes SHALL be ignored (state becomes SKIP).
REQ-016 If a received end < start, end SHALL be forced to start.
REQ-017 CASET or RASET completion SHALL load the write cursor to (xs, ys).
REQ-018 RAMWR entry SHALL load the cursor to (xs, ys); the first data byte is color[15:8], the second color[7:0].
REQ-019 On the second byte pix_valid SHALL pulse one cycle after byte completion with the current cursor and assembled color.
REQ-020 After each pixel: x increments; at x == xe, x := xs and y increments; at y == ye too, y := ys (wrap to window origin).
REQ-021 pix_valid and cmd_valid SHALL never assert in the same cycle.

Reset
REQ-022 Reset SHALL force: FSM IDLE, bit counter 0, window x 0..C_x_max, y 0..C_y_max, cursor (0,0), all outputs 0.
REQ-023 Reset mid-byte or mid-pixel SHALL discard the partial data; the next byte SHALL be taken as starting at the next edge with oled_cs low after reset deasserts.

Structure
REQ-024 Opcode constants (0x2A, 0x2B, 0x2C) and default window bounds SHALL live in shared package lcd_pkg, also used by the transmit driver.
REQ-025 Synchronizers and byte assembly SHALL be sub-module lcd_spi_deser (outputs byte, dc, byte_valid strobe); command/pixel decode SHALL be in lcd_spi_rx.

Verification
REQ-026 After reset, send RAMWR and then bytes F8 00 07 E0 -> pix (0,0,F800), then (1,0,07E0).
REQ-027 CASET 00 02 00 03, RASET 00 05 00 06, RAMWR, 5 pixels -> (2,5),(3,5),(2,6),(3,6),(2,5).
REQ-028 RAMWR, byte AA, then command 0x2C, then 12 34 -> single pix (0,0,1234); cmd_valid twice with 2C.
REQ-029 Raise oled_cs after 5 bits, lower it, send 8 bits of 0x2C with dc = 0 -> cmd_code 2C, no extra byte.
REQ-030 CASET 00 0A 00 04 -> window x 10..10; 3 pixels all at x = 10 with y incrementing.
REQ-031 Assert reset between the two bytes of a pixel -> no pix_valid; after reset, data bytes are ignored until RAMWR is received.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: constants and types shared by the LCD SPI receiver and the
// transmit driver.
//   OP_*       : command opcodes for window setup and memory write
//   DEF_*_MAX  : default last column / row index of the panel
//   rx_state_e : command decoder states
`timescale 1ns/1ps
package lcd_pkg;

  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_RASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;

  localparam int DEF_X_MAX = 127;
  localparam int DEF_Y_MAX = 159;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_SKIP
  } rx_state_e;

  // Decoder state entered on reception of a command byte.
  function automatic rx_state_e opcode_state(input logic [7:0] op);
    case (op)
      OP_CASET: return ST_CASET;
      OP_RASET: return ST_RASET;
      OP_RAMWR: return ST_RAMWR;
      default:  return ST_SKIP;
    endcase
  endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// lcd_spi_deser: synchronizes the SPI lines into clk and assembles bytes.
//   clk, reset          : system clock, synchronous active-high reset
//   oled_cs/clk/mosi/dc : asynchronous SPI lines (mode 0, MSB first)
//   rx_byte, rx_dc      : completed byte and its D/C classification
//   byte_valid          : one-cycle strobe when rx_byte/rx_dc are new
`timescale 1ns/1ps
module lcd_spi_deser (
  input  logic       clk,
  input  logic       reset,
  input  logic       oled_cs,
  input  logic       oled_clk,
  input  logic       oled_mosi,
  input  logic       oled_dc,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_valid
);

  // Bit order within the synchronizer vectors: {cs, sclk, mosi, dc}.
  localparam logic [3:0] SYNC_IDLE = 4'b1000;

  logic [3:0] meta_q,  meta_d;
  logic [3:0] sync_q,  sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d;
  logic       valid_q, valid_d;

  logic cs_s, sclk_s, mosi_s, dc_s, sclk_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= SYNC_IDLE;
      sync_q      <= SYNC_IDLE;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      dc_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      dc_q        <= dc_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    meta_d      = {oled_cs, oled_clk, oled_mosi, oled_dc};
    sync_d      = meta_q;
    {cs_s, sclk_s, mosi_s, dc_s} = sync_q;
    sclk_prev_d = sclk_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    dc_d        = dc_q;
    valid_d     = 1'b0;

    if (cs_s) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d  = {shift_q, mosi_s};
        dc_d    = dc_s;
        valid_d = 1'b1;
      end
    end
  end

  assign rx_byte    = byte_q;
  assign rx_dc      = dc_q;
  assign byte_valid = valid_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: decodes the LCD command stream and reports pixel writes.
//   clk, reset          : system clock, synchronous active-high reset
//   oled_cs/clk/mosi/dc : SPI lines from the LCD driver (asynchronous)
//   pix_valid           : one-cycle strobe, pixel written at (pix_x, pix_y)
//   pix_x, pix_y        : pixel address
//   pix_color           : RGB565 pixel data
//   cmd_valid, cmd_code : one-cycle strobe and opcode for each command byte
`timescale 1ns/1ps
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int C_color_bits = 16,
  parameter int C_x_max      = DEF_X_MAX,
  parameter int C_y_max      = DEF_Y_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    oled_cs,
  input  logic                    oled_clk,
  input  logic                    oled_mosi,
  input  logic                    oled_dc,
  output logic                    pix_valid,
  output logic [6:0]              pix_x,
  output logic [7:0]              pix_y,
  output logic [C_color_bits-1:0] pix_color,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_code
);

  localparam logic [6:0] X_MAX = 7'(C_x_max);
  localparam logic [7:0] Y_MAX = 8'(C_y_max);

  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       byte_valid;

  lcd_spi_deser u_deser (
    .clk        (clk),
    .reset      (reset),
    .oled_cs    (oled_cs),
    .oled_clk   (oled_clk),
    .oled_mosi  (oled_mosi),
    .oled_dc    (oled_dc),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .byte_valid (byte_valid)
  );

  rx_state_e state_q, state_d;

  logic [1:0]              idx_q, idx_d;
  logic [7:0]              start_lo_q, start_lo_d;
  logic [6:0]              xs_q, xs_d, xe_q, xe_d;
  logic [7:0]              ys_q, ys_d, ye_q, ye_d;
  logic [6:0]              cur_x_q, cur_x_d;
  logic [7:0]              cur_y_q, cur_y_d;
  logic                    hi_pending_q, hi_pending_d;
  logic [7:0]              color_hi_q, color_hi_d;
  logic                    pix_valid_q, pix_valid_d;
  logic [6:0]              pix_x_q, pix_x_d;
  logic [7:0]              pix_y_q, pix_y_d;
  logic [C_color_bits-1:0] pix_color_q, pix_color_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [7:0]              cmd_code_q, cmd_code_d;

  logic       cmd_byte, data_byte, param_last;
  logic [6:0] new_xs, new_xe;
  logic [7:0] new_ys, new_ye;

  assign cmd_byte   = byte_valid & ~rx_dc;
  assign data_byte  = byte_valid &  rx_dc;
  assign param_last = (idx_q == 2'd3);

  // State register (FSM and datapath)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      start_lo_q   <= '0;
      xs_q         <= '0;
      xe_q         <= X_MAX;
      ys_q         <= '0;
      ye_q         <= Y_MAX;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      hi_pending_q <= 1'b0;
      color_hi_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      start_lo_q   <= start_lo_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      hi_pending_q <= hi_pending_d;
      color_hi_q   <= color_hi_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cmd_byte) begin
      state_d = opcode_state(rx_byte);
    end else if (data_byte && (state_q == ST_CASET || state_q == ST_RASET) && param_last) begin
      state_d = ST_SKIP;
    end
  end

  // Window bounds from the completing parameter byte; end is clamped to start.
  always_comb begin
    new_xs = start_lo_q[6:0];
    new_xe = (rx_byte[6:0] < new_xs) ? new_xs : rx_byte[6:0];
    new_ys = start_lo_q;
    new_ye = (rx_byte < new_ys) ? new_ys : rx_byte;
  end

  // Output and datapath logic
  always_comb begin
    idx_d        = idx_q;
    start_lo_d   = start_lo_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    hi_pending_d = hi_pending_q;
    color_hi_d   = color_hi_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_color_d  = pix_color_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;

    if (cmd_byte) begin
      cmd_valid_d  = 1'b1;
      cmd_code_d   = rx_byte;
      idx_d        = '0;
      hi_pending_d = 1'b0;
      if (rx_byte == OP_RAMWR) begin
        cur_x_d = xs_q;
        cur_y_d = ys_q;
      end
    end else if (data_byte) begin
      case (state_q)
        ST_CASET, ST_RASET: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd1) start_lo_d = rx_byte;
          if (param_last) begin
            if (state_q == ST_CASET) begin
              xs_d    = new_xs;
              xe_d    = new_xe;
              cur_x_d = new_xs;
              cur_y_d = ys_q;
            end else begin
              ys_d    = new_ys;
              ye_d    = new_ye;
              cur_x_d = xs_q;
              cur_y_d = new_ys;
            end
          end
        end
        ST_RAMWR: begin
          if (!hi_pending_q) begin
            color_hi_d   = rx_byte;
            hi_pending_d = 1'b1;
          end else begin
            hi_pending_d = 1'b0;
            pix_valid_d  = 1'b1;
            pix_x_d      = cur_x_q;
            pix_y_d      = cur_y_q;
            pix_color_d  = C_color_bits'({color_hi_q, rx_byte});
            if (cur_x_q == xe_q) begin
              cur_x_d = xs_q;
              cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
`timescale 1ns/1ps
module tb_lcd_spi_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        oled_cs = 1'b1;
  logic        oled_clk = 1'b0;
  logic        oled_mosi = 1'b0;
  logic        oled_dc = 1'b0;
  logic        pix_valid;
  logic [6:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_color;
  logic        cmd_valid;
  logic [7:0]  cmd_code;

  typedef struct packed {
    logic [6:0]  x;
    logic [7:0]  y;
    logic [15:0] c;
  } pix_t;

  pix_t       exp_pix[$];
  logic [7:0] exp_cmd[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_spi_rx #(.C_color_bits(16), .C_x_max(127), .C_y_max(159)) dut (
    .clk       (clk),
    .reset     (reset),
    .oled_cs   (oled_cs),
    .oled_clk  (oled_clk),
    .oled_mosi (oled_mosi),
    .oled_dc   (oled_dc),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code)
  );

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    for (int i = 0; i < n; i++) begin
      oled_mosi = b[7-i];
      oled_dc   = dc;
      #40 oled_clk = 1'b1;
      #40 oled_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    oled_cs = 1'b0;
    #40;
    send_bits(b, 8, dc);
    #40 oled_cs = 1'b1;
    #80;
  endtask

  task automatic cmd(input logic [7:0] op);
    exp_cmd.push_back(op);
    send_byte(op, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic pixel(input logic [6:0] x, input logic [7:0] y, input logic [15:0] c);
    exp_pix.push_back({x, y, c});
    dat(c[15:8]);
    dat(c[7:0]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_pix.size() != 0 || exp_cmd.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_pix.size() != 0 || exp_cmd.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pix_left=%0d cmd_left=%0d required 0/0",
               exp_pix.size(), exp_cmd.size());
      exp_pix.delete();
      exp_cmd.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (pix_valid && cmd_valid) begin
          total++;
          bad++;
          $display("FAIL both_valid: pix_valid=1 cmd_valid=1 required not both");
        end
        if (pix_valid) begin
          total++;
          if (exp_pix.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pix: got (%0d,%0d,%h) required none", pix_x, pix_y, pix_color);
          end else begin
            pix_t e;
            e = exp_pix.pop_front();
            if ({pix_x, pix_y, pix_color} !== e) begin
              bad++;
              $display("FAIL pix: got (%0d,%0d,%h) required (%0d,%0d,%h)",
                       pix_x, pix_y, pix_color, e.x, e.y, e.c);
            end
          end
        end
        if (cmd_valid) begin
          total++;
          if (exp_cmd.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cmd: got %h required none", cmd_code);
          end else begin
            logic [7:0] e;
            e = exp_cmd.pop_front();
            if (cmd_code !== e) begin
              bad++;
              $display("FAIL cmd: got %h required %h", cmd_code, e);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_pix_x",     32'(pix_x),     32'd0);
    check("rst_pix_y",     32'(pix_y),     32'd0);
    check("rst_pix_color", 32'(pix_color), 32'd0);
    check("rst_cmd_code",  32'(cmd_code),  32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic RAMWR after reset
    cmd(8'h2C);
    pixel(7'd0, 8'd0, 16'hF800);
    pixel(7'd1, 8'd0, 16'h07E0);

    // 2x2 window with x and y wrap
    do_reset();
    cmd(8'h2A); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    dat(8'h77);  // extra parameter byte, ignored in SKIP
    cmd(8'h2C);
    pixel(7'd2, 8'd5, 16'h0001);
    pixel(7'd3, 8'd5, 16'h0002);
    pixel(7'd2, 8'd6, 16'h0003);
    pixel(7'd3, 8'd6, 16'h0004);
    pixel(7'd2, 8'd5, 16'h0005);

    // Command mid-pixel drops the pending high byte
    do_reset();
    cmd(8'h2C);
    dat(8'hAA);
    cmd(8'h2C);
    pixel(7'd0, 8'd0, 16'h1234);

    // Partial byte aborted by cs, then clean command; unknown opcode skips data
    do_reset();
    oled_cs = 1'b0;
    #40;
    send_bits(8'hFF, 5, 1'b1);
    #40 oled_cs = 1'b1;
    #80;
    cmd(8'h2C);
    pixel(7'd0, 8'd0, 16'hBEEF);
    cmd(8'h36);
    dat(8'h11); dat(8'h22);
    cmd(8'h2C);
    pixel(7'd0, 8'd0, 16'hCAFE);

    // end < start clamps end to start
    do_reset();
    cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h04);
    cmd(8'h2C);
    pixel(7'd10, 8'd0, 16'hA001);
    pixel(7'd10, 8'd1, 16'hA002);
    pixel(7'd10, 8'd2, 16'hA003);

    // Reset between pixel bytes; data ignored until RAMWR
    do_reset();
    cmd(8'h2C);
    dat(8'h11);
    do_reset();
    dat(8'h22);
    dat(8'h33);
    cmd(8'h2C);
    pixel(7'd0, 8'd0, 16'h4455);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
